// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Optional packet locking is enabled by defining STREAM_MUX_LOCK_EN.
package stream_mux_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N     = 4;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Pointer successor that wraps at the channel count, not at 2^SEL_W.
    function automatic int next_ptr(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// scanning cyclically. While lock is set only lock_ch may be granted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             lock,
    input  logic [SEL_W-1:0] lock_ch,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    // Cyclic priority scan starting at ptr, or a single-channel check when locked.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (lock) begin
            if (req[lock_ch]) begin
                grant[lock_ch] = 1'b1;
                grant_idx      = lock_ch;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = SEL_W'(idx);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration and a
// registered output stage. Define STREAM_MUX_LOCK_EN to keep a channel
// granted from its first beat until its last beat (packet lock).
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             load_en;
    logic             xfer;
    logic             lock;
    logic [SEL_W-1:0] lock_ch;

    // Output register can take a word when empty or being drained this cycle.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = |in_ready;

    rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .lock      (lock),
        .lock_ch   (lock_ch),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR selection of the granted channel's data word.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: out_data is cleared on reset too, since the reset output word must read 0, not X.
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (xfer) begin
                // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
                out_data  <= sel_data;
                out_last  <= in_last[grant_idx];
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
`ifdef STREAM_MUX_LOCK_EN
                if (in_last[grant_idx]) ptr <= SEL_W'(next_ptr(int'(grant_idx), N));
`else
                ptr <= SEL_W'(next_ptr(int'(grant_idx), N));
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock: set on a non-last beat, released by the locked channel's last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            if (in_last[grant_idx]) begin
                lock <= 1'b0;
            end else begin
                lock    <= 1'b1;
                lock_ch <= grant_idx;
            end
        end
    end
`else
    assign lock    = 1'b0;
    assign lock_ch = '0;
`endif

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel, WIDTH-bit valid/ready stream multiplexer with round-robin arbitration and a registered output stage.
- Sequential successor to the combinational 2:1 mux: generalised in channel count and width, and adds handshake, fairness and optional packet locking.
- Sits between multiple producers (e.g. memory/IO request sources) and a single consumer in the datapath.

Parameters:
- WIDTH, 16, data bits per channel.
- N, 4, number of input channels; legal range 1..16, need not be a power of two.
- SEL_W, max(1, clog2(N)), width of the channel index (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-packet marker; passed through to out_last.
- in_ready  out  N  per-channel ready (combinational).
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  registered valid.
- out_last  out  1  registered last.
- out_sel  out  SEL_W  index of the channel that supplied the current output word.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer ptr=0, lock=0. While rst_n=0, in_ready is forced to all zeros.
- load_en = !out_valid || out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Arbitration (combinational): grant is the first i with in_valid[i]=1, scanning cyclically ptr, ptr+1, ..., N-1, 0, ..., ptr-1. grant is one-hot or zero.
- in_ready[i] = rst_n && load_en && grant[i]. At most one in_ready is high per cycle, and never toward a channel whose valid is low.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - next cycle: out_data=in_data[g], out_last=in_last[g], out_sel=g, out_valid=1.
  - ptr <= (g==N-1) ? 0 : g+1. Wrap is at N, not 2^SEL_W.
- Latency is 1 cycle input to output. Sustained throughput is 1 word/cycle when out_ready=1.
- load_en=1 with no grant: out_valid <= 0 (if it was consumed). out_data, out_last and out_sel hold their values.
- out_valid=1 and out_ready=0: all output registers hold, in_ready=0, ptr holds.
- Input handshake rule: an input may deassert in_valid without a handshake. The block does not require valid to be sticky, but upstream producers are expected to keep it.
- N=1: ptr stays 0 and the block degenerates to a one-stage pipeline register.
- Reset asserted mid-stream: the word in the output register is dropped, and the lock and pointer clear.

Optional Feature:
- STREAM_MUX_LOCK_EN (packet lock).
  - Defined: a transfer from channel g with in_last[g]=0 sets lock=1 and lock_ch=g. While lock=1, grant considers only lock_ch; other channels wait even when valid. A transfer from lock_ch with in_last=1 clears lock. ptr advances only on last beats. Reset clears lock.
  - Undefined: no lock state. Arbitration is per word, and in_last is only passed through.

Decomposition:
- Package stream_mux_pkg:
  - sel_width(n) constant function;
  - default WIDTH/N localparams;
  - next_ptr(g, n) wrap function.
- Sub-module rr_arbiter (parameter N): in req[N], ptr[SEL_W], optional lock/lock_ch; out grant[N], grant_idx[SEL_W]. Purely combinational.
- stream_mux_rr owns ptr, lock and the output register.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0; on release, the first grant goes to ch0.
- Round-robin: N=4, all valid, out_ready=1, ch i data=0x1000+i -> out_data sequence 0x1000,0x1001,0x1002,0x1003,0x1000, with out_valid high every cycle after the first.
- Skip and wrap: only ch1 and ch3 valid, ptr=2 -> ch3 granted first, then ch1, then ch3; ptr never lands on an idle channel's turn.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=0x1002 -> output holds 0x1002, in_ready=0000; out_ready=1 -> the next word appears the following cycle.
- Non-power-of-two: N=3, all valid -> out_sel sequence 0,1,2,0, never 3.
- Lock (STREAM_MUX_LOCK_EN): ch0 sends 3 words with last on word 3 while ch1 is valid -> out_sel=0,0,0 then 1. With the macro undefined -> out_sel=0,1,0,1.
